hazard_stall_ctrl: RTL

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl_if.sv | 34 +++
 rtl/hazard_stall_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_if
// Description : Pipeline-side bundle for the load-use hazard stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic                   ID_EX_MemRead_i;
    logic [4:0]             ID_EX_RDaddr_i;
    logic [5*NUM_SRC-1:0]   IF_ID_RSaddr_i;
    logic [NUM_SRC-1:0]     IF_ID_RSuse_i;
    logic                   Flush_i;
    logic                   CntClr_i;
    logic                   PCWrite_o;
    logic                   IF_ID_Write_o;
    logic                   ID_Flush_lwstall_o;
    logic [CNT_W-1:0]       StallCnt_o;

    modport master (
        output ID_EX_MemRead_i, ID_EX_RDaddr_i, IF_ID_RSaddr_i, IF_ID_RSuse_i,
               Flush_i, CntClr_i,
        input  PCWrite_o, IF_ID_Write_o, ID_Flush_lwstall_o, StallCnt_o
    );

    modport slave (
        input  ID_EX_MemRead_i, ID_EX_RDaddr_i, IF_ID_RSaddr_i, IF_ID_RSuse_i,
               Flush_i, CntClr_i,
        output PCWrite_o, IF_ID_Write_o, ID_Flush_lwstall_o, StallCnt_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Load-use hazard detection with a multi-cycle load tracker and
//               a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int LOAD_LAT = 2,
    parameter int NUM_SRC  = 2,
    parameter int CNT_W    = 16
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                    w_ex_vld;
    logic [LOAD_LAT-1:0]     w_stg_vld;
    logic [5*LOAD_LAT-1:0]   w_stg_rd;
    logic [NUM_SRC-1:0]      w_hit;
    logic                    w_hazard;
    logic [CNT_W-1:0]        r_cnt;

    // A load to x0 produces nothing worth waiting for.
    assign w_ex_vld = bus.ID_EX_MemRead_i && (bus.ID_EX_RDaddr_i != 5'd0);

    generate
        if (LOAD_LAT > 1) begin : g_tracker
            logic [LOAD_LAT-1:1]   r_trk_vld;
            logic [5*LOAD_LAT-1:5] r_trk_rd;

            // Shifts every edge regardless of stall: the bubble is what moves the load along.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_trk_vld <= '0;
                    r_trk_rd  <= '0;
                end else begin
                    r_trk_vld <= w_stg_vld[LOAD_LAT-2:0];
                    r_trk_rd  <= w_stg_rd[5*LOAD_LAT-6:0];
                end
            end

            assign w_stg_vld = {r_trk_vld, w_ex_vld};
            assign w_stg_rd  = {r_trk_rd, bus.ID_EX_RDaddr_i};
        end else begin : g_no_tracker
            assign w_stg_vld = w_ex_vld;
            assign w_stg_rd  = bus.ID_EX_RDaddr_i;
        end
    endgenerate

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = 0; j < LOAD_LAT; j++) begin
                if (bus.IF_ID_RSuse_i[k] &&
                    (bus.IF_ID_RSaddr_i[5*k +: 5] != 5'd0) &&
                    w_stg_vld[j] &&
                    (w_stg_rd[5*j +: 5] == bus.IF_ID_RSaddr_i[5*k +: 5])) begin
                    w_hit[k] = 1'b1;
                end
            end
        end
    end

    // Gating with rst_i keeps the pipeline free-running while reset is held.
    assign w_hazard = rst_i && (|w_hit) && !bus.Flush_i;

    assign bus.PCWrite_o          = !w_hazard;
    assign bus.IF_ID_Write_o      = !w_hazard;
    assign bus.ID_Flush_lwstall_o = w_hazard;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (bus.CntClr_i) begin
            r_cnt <= '0;
        end else if (w_hazard && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign bus.StallCnt_o = r_cnt;

endmodule
`default_nettype wire
